mmio_d_mem_arb: RTL and testbench
=================================

MMIO_D_MEM_ARB -- requirements
Module: mmio_d_mem_arb

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the fabric request buffer depth in entries (power of 2, 2..8).
REQ-002 Parameter STARVE_TH, default 16, SHALL set the consecutive-wait-cycle count at which fabric starvation is flagged.
REQ-003 QClk  in  1  SHALL be the single clock, rising edge.
REQ-004 RstQnnnH  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 CoreAdrsQ102H in 32, CoreWrDataQ102H in 32, CoreByteEnQ102H in 4, CoreWrQ102H in 1, CoreRdQ102H in 1 SHALL be the core data request.
REQ-006 CoreRdDataQ103H  out  32  SHALL be the core read data.
REQ-007 FabReqValidQnnnH in 1, FabReqWrQnnnH in 1 (1=write, 0=read), FabReqAdrsQnnnH in 32, FabReqDataQnnnH in 32, FabReqByteEnQnnnH in 4 SHALL be the fabric request.
REQ-008 FabReqReadyQnnnH  out  1  SHALL be the fabric request ready.
REQ-009 FabRspValidQnnnH out 1, FabRspDataQnnnH out 32 SHALL be the fabric response (no backpressure).
REQ-010 MemAdrsQ102H out 32, MemWrDataQ102H out 32, MemByteEnQ102H out 4, MemRdQ102H out 1, MemWrQ102H out 1 SHALL drive the data memory.
REQ-011 MemRdDataQ103H  in  32  SHALL be the memory read data, valid one cycle after a read.
REQ-012 FabPendCntQnnnH out 4, FabStarveQnnnH out 1 SHALL report buffer occupancy and starvation.

Function
REQ-013 A fabric request SHALL be pushed into the FIFO on a rising edge with FabReqValidQnnnH=1 and FabReqReadyQnnnH=1.
REQ-014 FabReqReadyQnnnH SHALL equal (occupancy < FIFO_DEPTH), computed from the registered count only; a pop in the same cycle SHALL NOT raise ready.
REQ-015 Core SHALL have absolute priority: when CoreRdQ102H or CoreWrQ102H is 1, Mem* outputs SHALL be combinational copies of Core*, and no pop SHALL occur.
REQ-016 When the core is idle and the FIFO is non-empty, Mem* SHALL be driven from the FIFO head and the head SHALL be popped at the clock edge.
REQ-017 When no source is granted, Mem* outputs SHALL all be 0.
REQ-018 CoreRdQ102H=1 with CoreWrQ102H=1 SHALL be treated as a write (MemRdQ102H=0).
REQ-019 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 A fabric grant SHALL be recorded in a one-cycle pipeline register (valid, wr flag); in the following cycle FabRspValidQnnnH SHALL be 1 for exactly one cycle.
REQ-021 FabRspDataQnnnH SHALL equal MemRdDataQ103H for a fabric read response, 32'h0 for a fabric write acknowledge, and 32'h0 when FabRspValidQnnnH=0.
REQ-022 CoreRdDataQ103H SHALL equal MemRdDataQ103H unconditionally (one-cycle read latency, no extra delay).
REQ-023 An 8-bit saturating wait counter SHALL increment each cycle in which the FIFO is non-empty and no pop occurs, clear on any pop or when empty; FabStarveQnnnH SHALL be 1 while count >= STARVE_TH.
REQ-024 FabPendCntQnnnH SHALL equal the registered FIFO occupancy.

Reset
REQ-025 On RstQnnnH=0 the FIFO pointers, occupancy, response pipeline, and wait counter SHALL clear asynchronously.
REQ-026 While RstQnnnH=0, MemRdQ102H, MemWrQ102H, FabRspValidQnnnH, FabReqReadyQnnnH and FabStarveQnnnH SHALL be 0 regardless of inputs.
REQ-027 Reset mid-operation SHALL discard buffered requests and any in-flight fabric response without generating FabRspValidQnnnH.

Structure
REQ-028 The fabric request struct t_fab_req (wr, adrs, data, byteen) and the default FIFO_DEPTH/STARVE_TH constants SHALL reside in gpc_4t_pkg.
REQ-029 The buffer SHALL be a sub-module fab_req_fifo (push/pop/full/empty/count, data t_fab_req); arbitration and response tracking SHALL remain in mmio_d_mem_arb.

Verification
REQ-030 Core idle, fabric write 0x100 data 0xDEADBEEF byteen 4'hF, then fabric read 0x100 -> MemWrQ102H one cycle, write ack with data 0, then FabRspDataQnnnH=0xDEADBEEF one cycle after read grant.
REQ-031 Core reads every cycle for 20 cycles with one fabric request queued -> zero fabric grants, FabStarveQnnnH rises after 16 waiting cycles, clears on first idle-cycle pop.
REQ-032 Push 4 fabric requests with core busy -> FabPendCntQnnnH=4, FabReqReadyQnnnH=0; fifth request held until a pop, then accepted next cycle.
REQ-033 Core read 0x200 and fabric read 0x300 presented in the same cycle -> core served first, fabric served next idle cycle, CoreRdDataQ103H and FabRspDataQnnnH each carry their own address's data.
REQ-034 Assert RstQnnnH=0 with 3 requests buffered and one response in flight -> count=0, no FabRspValidQnnnH, Mem strobes 0 during reset.
REQ-035 CoreRdQ102H and CoreWrQ102H both 1 -> MemWrQ102H=1, MemRdQ102H=0.

Source files
------------

// File: rtl/gpc_4t_pkg.sv
// Shared types and default sizing for the data-memory arbiter slice.
package gpc_4t_pkg;

    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_STARVE_TH  = 16;

    typedef struct packed {
        logic        wr;
        logic [31:0] adrs;
        logic [31:0] data;
        logic [3:0]  byteen;
    } t_fab_req;

endpackage

// File: rtl/fab_req_fifo.sv
// Fabric request buffer: power-of-2 circular FIFO with registered occupancy.
module fab_req_fifo
    import gpc_4t_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     QClk,
    input  logic                     RstQnnnH,
    input  logic                     push,
    input  logic                     pop,
    input  t_fab_req                 pushData,
    output t_fab_req                 headData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;
    t_fab_req      store [DEPTH];

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = store[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge QClk) begin
        if (doPush) store[wrPtr] <= pushData;
    end

endmodule

// File: rtl/mmio_d_mem_arb.sv
// Data-memory arbiter: core has absolute priority, fabric requests are buffered
// and served in idle cycles with a one-cycle response pipeline and starvation flag.
module mmio_d_mem_arb
    import gpc_4t_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned STARVE_TH  = DEF_STARVE_TH
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic [31:0] CoreAdrsQ102H,
    input  logic [31:0] CoreWrDataQ102H,
    input  logic [3:0]  CoreByteEnQ102H,
    input  logic        CoreWrQ102H,
    input  logic        CoreRdQ102H,
    output logic [31:0] CoreRdDataQ103H,
    input  logic        FabReqValidQnnnH,
    input  logic        FabReqWrQnnnH,
    input  logic [31:0] FabReqAdrsQnnnH,
    input  logic [31:0] FabReqDataQnnnH,
    input  logic [3:0]  FabReqByteEnQnnnH,
    output logic        FabReqReadyQnnnH,
    output logic        FabRspValidQnnnH,
    output logic [31:0] FabRspDataQnnnH,
    output logic [31:0] MemAdrsQ102H,
    output logic [31:0] MemWrDataQ102H,
    output logic [3:0]  MemByteEnQ102H,
    output logic        MemRdQ102H,
    output logic        MemWrQ102H,
    input  logic [31:0] MemRdDataQ103H,
    output logic [3:0]  FabPendCntQnnnH,
    output logic        FabStarveQnnnH
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          coreReq;
    logic          fabGrant;
    logic          fifoPush;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [CW-1:0] fifoCount;
    t_fab_req      pushReq;
    t_fab_req      headReq;
    logic          rspValid;
    logic          rspWr;
    logic [7:0]    waitCnt;

    assign coreReq  = CoreRdQ102H | CoreWrQ102H;
    assign fabGrant = RstQnnnH && !coreReq && !fifoEmpty;
    assign fifoPush = FabReqValidQnnnH && FabReqReadyQnnnH;
    assign pushReq  = '{wr: FabReqWrQnnnH, adrs: FabReqAdrsQnnnH,
                        data: FabReqDataQnnnH, byteen: FabReqByteEnQnnnH};

    fab_req_fifo #(.DEPTH(FIFO_DEPTH)) uFabReqFifo (
        .QClk     (QClk),
        .RstQnnnH (RstQnnnH),
        .push     (fifoPush),
        .pop      (fabGrant),
        .pushData (pushReq),
        .headData (headReq),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    // Ready comes from the registered count only, so a same-cycle pop never raises it.
    assign FabReqReadyQnnnH = RstQnnnH && !fifoFull;
    assign FabPendCntQnnnH  = 4'(fifoCount);
    assign CoreRdDataQ103H  = MemRdDataQ103H;
    assign FabRspValidQnnnH = rspValid;
    assign FabRspDataQnnnH  = (rspValid && !rspWr) ? MemRdDataQ103H : '0;
    assign FabStarveQnnnH   = RstQnnnH && ({24'd0, waitCnt} >= STARVE_TH);

    always_comb begin
        MemAdrsQ102H   = '0;
        MemWrDataQ102H = '0;
        MemByteEnQ102H = '0;
        MemRdQ102H     = 1'b0;
        MemWrQ102H     = 1'b0;
        if (coreReq) begin
            MemAdrsQ102H   = CoreAdrsQ102H;
            MemWrDataQ102H = CoreWrDataQ102H;
            MemByteEnQ102H = CoreByteEnQ102H;
            MemWrQ102H     = CoreWrQ102H;
            MemRdQ102H     = CoreRdQ102H && !CoreWrQ102H;
        end else if (fabGrant) begin
            MemAdrsQ102H   = headReq.adrs;
            MemWrDataQ102H = headReq.data;
            MemByteEnQ102H = headReq.byteen;
            MemWrQ102H     = headReq.wr;
            MemRdQ102H     = !headReq.wr;
        end
        if (!RstQnnnH) begin
            MemRdQ102H = 1'b0;
            MemWrQ102H = 1'b0;
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            rspValid <= 1'b0;
            rspWr    <= 1'b0;
            waitCnt  <= '0;
        end else begin
            rspValid <= fabGrant;
            rspWr    <= headReq.wr;
            if (fifoEmpty || fabGrant)
                waitCnt <= '0;
            else if (waitCnt != 8'hFF)
                waitCnt <= waitCnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mmio_d_mem_arb.sv
// Randomized and directed bench for mmio_d_mem_arb against a queue-based model.
module tb_mmio_d_mem_arb;
    import gpc_4t_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TH    = 16;

    logic        QClk = 1'b0;
    logic        RstQnnnH = 1'b0;
    logic [31:0] CoreAdrsQ102H = '0, CoreWrDataQ102H = '0;
    logic [3:0]  CoreByteEnQ102H = '0;
    logic        CoreWrQ102H = 1'b0, CoreRdQ102H = 1'b0;
    logic [31:0] CoreRdDataQ103H;
    logic        FabReqValidQnnnH = 1'b0, FabReqWrQnnnH = 1'b0;
    logic [31:0] FabReqAdrsQnnnH = '0, FabReqDataQnnnH = '0;
    logic [3:0]  FabReqByteEnQnnnH = '0;
    logic        FabReqReadyQnnnH, FabRspValidQnnnH;
    logic [31:0] FabRspDataQnnnH;
    logic [31:0] MemAdrsQ102H, MemWrDataQ102H;
    logic [3:0]  MemByteEnQ102H;
    logic        MemRdQ102H, MemWrQ102H;
    logic [31:0] MemRdDataQ103H = '0;
    logic [3:0]  FabPendCntQnnnH;
    logic        FabStarveQnnnH;

    always #5 QClk = ~QClk;

    mmio_d_mem_arb #(.FIFO_DEPTH(DEPTH), .STARVE_TH(TH)) dut (
        .QClk(QClk), .RstQnnnH(RstQnnnH),
        .CoreAdrsQ102H(CoreAdrsQ102H), .CoreWrDataQ102H(CoreWrDataQ102H),
        .CoreByteEnQ102H(CoreByteEnQ102H), .CoreWrQ102H(CoreWrQ102H),
        .CoreRdQ102H(CoreRdQ102H), .CoreRdDataQ103H(CoreRdDataQ103H),
        .FabReqValidQnnnH(FabReqValidQnnnH), .FabReqWrQnnnH(FabReqWrQnnnH),
        .FabReqAdrsQnnnH(FabReqAdrsQnnnH), .FabReqDataQnnnH(FabReqDataQnnnH),
        .FabReqByteEnQnnnH(FabReqByteEnQnnnH), .FabReqReadyQnnnH(FabReqReadyQnnnH),
        .FabRspValidQnnnH(FabRspValidQnnnH), .FabRspDataQnnnH(FabRspDataQnnnH),
        .MemAdrsQ102H(MemAdrsQ102H), .MemWrDataQ102H(MemWrDataQ102H),
        .MemByteEnQ102H(MemByteEnQ102H), .MemRdQ102H(MemRdQ102H),
        .MemWrQ102H(MemWrQ102H), .MemRdDataQ103H(MemRdDataQ103H),
        .FabPendCntQnnnH(FabPendCntQnnnH), .FabStarveQnnnH(FabStarveQnnnH)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: request queue, response slot, wait count.
    t_fab_req    mq[$];
    bit          mRspV, mRspWr;
    logic [31:0] mRspData;
    int unsigned mWait;

    // Memory environment.
    logic [31:0] memArr [logic [31:0]];
    bit          envRd, envWr;
    logic [31:0] envRdA, envWrA, envWrD;
    logic [3:0]  envWrBe;

    // Snapshot of DUT outputs at the last sample point, for literal pins.
    logic        oMemRd, oMemWr, oReady, oRspV, oStarve;
    logic [31:0] oMemAdrs, oMemWrData, oRspD, oCoreRd;
    logic [3:0]  oPend;

    bit rstReq = 1'b0;

    function automatic logic [31:0] memVal(input logic [31:0] a);
        return memArr.exists(a) ? memArr[a] : {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mRspV = 1'b0; mRspWr = 1'b0; mRspData = '0; mWait = 0;
    endtask

    task automatic compare();
        logic        cReq, eRd, eWr;
        logic [31:0] eA, eD;
        logic [3:0]  eBe;
        t_fab_req    h;
        oMemRd = MemRdQ102H; oMemWr = MemWrQ102H; oReady = FabReqReadyQnnnH;
        oRspV = FabRspValidQnnnH; oStarve = FabStarveQnnnH; oMemAdrs = MemAdrsQ102H;
        oMemWrData = MemWrDataQ102H; oRspD = FabRspDataQnnnH; oCoreRd = CoreRdDataQ103H;
        oPend = FabPendCntQnnnH;
        if (!RstQnnnH) begin
            chk("rst_memRd", 32'(MemRdQ102H), 32'd0);
            chk("rst_memWr", 32'(MemWrQ102H), 32'd0);
            chk("rst_ready", 32'(FabReqReadyQnnnH), 32'd0);
            chk("rst_starve", 32'(FabStarveQnnnH), 32'd0);
            chk("rst_rspValid", 32'(FabRspValidQnnnH), 32'd0);
            chk("rst_rspData", FabRspDataQnnnH, 32'd0);
            chk("rst_pendCnt", 32'(FabPendCntQnnnH), 32'd0);
            return;
        end
        cReq = CoreRdQ102H | CoreWrQ102H;
        eA = '0; eD = '0; eBe = '0; eRd = 1'b0; eWr = 1'b0;
        if (cReq) begin
            eA = CoreAdrsQ102H; eD = CoreWrDataQ102H; eBe = CoreByteEnQ102H;
            eWr = CoreWrQ102H; eRd = CoreRdQ102H && !CoreWrQ102H;
        end else if (mq.size() > 0) begin
            h = mq[0];
            eA = h.adrs; eD = h.data; eBe = h.byteen; eWr = h.wr; eRd = !h.wr;
        end
        chk("memAdrs", MemAdrsQ102H, eA);
        chk("memWrData", MemWrDataQ102H, eD);
        chk("memByteEn", 32'(MemByteEnQ102H), 32'(eBe));
        chk("memRd", 32'(MemRdQ102H), 32'(eRd));
        chk("memWr", 32'(MemWrQ102H), 32'(eWr));
        chk("ready", 32'(FabReqReadyQnnnH), 32'(mq.size() < DEPTH));
        chk("pendCnt", 32'(FabPendCntQnnnH), 32'(mq.size()));
        chk("starve", 32'(FabStarveQnnnH), 32'(mWait >= TH));
        chk("rspValid", 32'(FabRspValidQnnnH), 32'(mRspV));
        chk("rspData", FabRspDataQnnnH, (mRspV && !mRspWr) ? mRspData : 32'd0);
        chk("coreRdData", CoreRdDataQ103H, MemRdDataQ103H);
    endtask

    task automatic modelAdvance();
        bit       cReq, grant, pushIt;
        t_fab_req h;
        cReq   = CoreRdQ102H | CoreWrQ102H;
        grant  = !cReq && mq.size() > 0;
        pushIt = FabReqValidQnnnH && mq.size() < DEPTH;
        if (mq.size() == 0 || grant) mWait = 0;
        else if (mWait < 255) mWait++;
        mRspV = grant;
        if (grant) begin
            h = mq.pop_front();
            mRspWr = h.wr;
            mRspData = h.wr ? 32'd0 : memVal(h.adrs);
        end
        if (pushIt)
            mq.push_back('{wr: FabReqWrQnnnH, adrs: FabReqAdrsQnnnH,
                           data: FabReqDataQnnnH, byteen: FabReqByteEnQnnnH});
    endtask

    task automatic step(input bit midRst = 1'b0);
        logic [31:0] v;
        @(negedge QClk);
        RstQnnnH = rstReq;
        #1;
        if (!RstQnnnH) modelReset();
        compare();
        if (midRst) begin
            RstQnnnH = 1'b0;
            rstReq = 1'b0;
            #1;
            modelReset();
            compare();
        end
        envRd = MemRdQ102H; envRdA = MemAdrsQ102H;
        envWr = MemWrQ102H; envWrA = MemAdrsQ102H;
        envWrD = MemWrDataQ102H; envWrBe = MemByteEnQ102H;
        if (RstQnnnH) modelAdvance();
        @(posedge QClk);
        #1;
        MemRdDataQ103H = envRd ? memVal(envRdA) : $urandom;
        if (envWr) begin
            v = memVal(envWrA);
            for (int b = 0; b < 4; b++)
                if (envWrBe[b]) v[8*b +: 8] = envWrD[8*b +: 8];
            memArr[envWrA] = v;
        end
    endtask

    task automatic setCore(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        CoreRdQ102H = rd; CoreWrQ102H = wr; CoreAdrsQ102H = a;
        CoreWrDataQ102H = d; CoreByteEnQ102H = be;
    endtask

    task automatic setFab(input bit v, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        FabReqValidQnnnH = v; FabReqWrQnnnH = wr; FabReqAdrsQnnnH = a;
        FabReqDataQnnnH = d; FabReqByteEnQnnnH = be;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        modelReset();
        rstReq = 1'b0;
        setCore(1, 0, 32'h10, 32'h0, 4'hF);
        step(); step();
        chk("pin_rst_pend", 32'(oPend), 32'd0);
        chk("pin_rst_memRd", 32'(oMemRd), 32'd0);
        rstReq = 1'b1;
        setCore(0, 0, '0, '0, '0);
        step();

        // Fabric write then read of the same word.
        setFab(1, 1, 32'h100, 32'hDEADBEEF, 4'hF); step();
        setFab(0, 0, '0, '0, '0); step();
        chk("pin_wr_memWr", 32'(oMemWr), 32'd1);
        chk("pin_wr_adrs", oMemAdrs, 32'h100);
        chk("pin_wr_data", oMemWrData, 32'hDEADBEEF);
        setFab(1, 0, 32'h100, 32'h0, 4'hF); step();
        chk("pin_wrack_valid", 32'(oRspV), 32'd1);
        chk("pin_wrack_data", oRspD, 32'h0);
        chk("pin_wr_once", 32'(oMemWr), 32'd0);
        setFab(0, 0, '0, '0, '0); step();
        chk("pin_rd_memRd", 32'(oMemRd), 32'd1);
        chk("pin_rd_noRsp", 32'(oRspV), 32'd0);
        step();
        chk("pin_rd_valid", 32'(oRspV), 32'd1);
        chk("pin_rd_data", oRspD, 32'hDEADBEEF);
        step();
        chk("pin_rsp_oneCycle", 32'(oRspV), 32'd0);

        // Read and write strobes together act as a write.
        setCore(1, 1, 32'h140, 32'h12345678, 4'h3); step();
        chk("pin_rdwr_memWr", 32'(oMemWr), 32'd1);
        chk("pin_rdwr_memRd", 32'(oMemRd), 32'd0);
        setCore(0, 0, '0, '0, '0); step();

        // Starvation under continuous core reads.
        setCore(1, 0, 32'h180, '0, 4'hF);
        setFab(1, 0, 32'h1C0, '0, 4'hF); step();
        setFab(0, 0, '0, '0, '0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 15) chk("pin_starve_15", 32'(oStarve), 32'd0);
            if (i == 16) chk("pin_starve_16", 32'(oStarve), 32'd1);
        end
        setCore(0, 0, '0, '0, '0); step();
        chk("pin_starve_popCycle", 32'(oStarve), 32'd1);
        chk("pin_starve_grantAdrs", oMemAdrs, 32'h1C0);
        step();
        chk("pin_starve_cleared", 32'(oStarve), 32'd0);

        // Fill the buffer while the core is busy; fifth request waits for a pop.
        setCore(1, 0, 32'h20, '0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            setFab(1, 1, 32'h200 + 32'(4 * k), 32'hA0 + 32'(k), 4'hF);
            step();
        end
        setFab(1, 0, 32'h240, '0, 4'hF); step();
        chk("pin_full_pend", 32'(oPend), 32'd4);
        chk("pin_full_ready", 32'(oReady), 32'd0);
        setCore(0, 0, '0, '0, '0); step();
        chk("pin_popNoReady", 32'(oReady), 32'd0);
        chk("pin_pop_adrs", oMemAdrs, 32'h200);
        setCore(1, 0, 32'h20, '0, 4'hF); step();
        chk("pin_afterPop_ready", 32'(oReady), 32'd1);
        setFab(0, 0, '0, '0, '0); step();
        chk("pin_fifth_pend", 32'(oPend), 32'd4);
        setCore(0, 0, '0, '0, '0);
        for (int k = 0; k < 6; k++) step();

        // Same-cycle core and fabric reads.
        setCore(1, 0, 32'h200, '0, 4'hF);
        setFab(1, 0, 32'h300, '0, 4'hF); step();
        chk("pin_both_coreAdrs", oMemAdrs, 32'h200);
        setCore(0, 0, '0, '0, '0);
        setFab(0, 0, '0, '0, '0); step();
        chk("pin_both_fabAdrs", oMemAdrs, 32'h300);
        chk("pin_both_coreData", oCoreRd, 32'h000000A0);
        step();
        chk("pin_both_fabRsp", oRspD, 32'h0300FCFF);
        step();

        // Reset with three buffered requests and a grant in progress.
        setCore(1, 0, 32'h30, '0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            setFab(1, 0, 32'h500 + 32'(4 * k), '0, 4'hF);
            step();
        end
        setFab(0, 0, '0, '0, '0);
        setCore(0, 0, '0, '0, '0); step(1'b1);
        chk("pin_midrst_pend", 32'(oPend), 32'd0);
        setCore(1, 1, 32'h40, 32'h1, 4'hF); step();
        chk("pin_inrst_memWr", 32'(oMemWr), 32'd0);
        chk("pin_inrst_rspV", 32'(oRspV), 32'd0);
        rstReq = 1'b1;
        setCore(0, 0, '0, '0, '0); step();
        chk("pin_afterRst_rspV", 32'(oRspV), 32'd0);
        chk("pin_afterRst_pend", 32'(oPend), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            rstReq = ($urandom_range(0, 79) != 0);
            r = $urandom_range(0, 9);
            setCore(r < 3 || r == 4, r == 3 || r == 4, 32'h400 + 32'(4 * $urandom_range(0, 7)),
                    $urandom, 4'($urandom));
            setFab($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   32'h400 + 32'(4 * $urandom_range(0, 7)), $urandom, 4'($urandom));
            step($urandom_range(0, 119) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
